cook_timer: RTL

COOK_TIMER -- requirements
Module: cook_timer

---
 rtl/cook_pkg.sv | 22 ++
 rtl/cook_bcd_split.sv | 25 ++
 rtl/cook_timer.sv | 114 +++++++++++
 3 files changed

// File: rtl/cook_pkg.sv
// Shared constants and state type for the cooking countdown timer.
package cook_pkg;

    localparam int REM_W       = 13;
    localparam int MAX_SECONDS = 5999;
    localparam int SEC_STEP    = 10;
    localparam int MIN_STEP    = 60;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } cook_state_t;

    // Add-and-clamp for the remaining-seconds counter; sum carries one extra bit.
    function automatic logic [REM_W-1:0] sat_seconds(input logic [REM_W:0] sum);
        if (sum > (REM_W+1)'(MAX_SECONDS)) return REM_W'(MAX_SECONDS);
        return sum[REM_W-1:0];
    endfunction

endpackage

// File: rtl/cook_bcd_split.sv
// Combinational split of a seconds count (0..5999) into mm:ss BCD digits.
module cook_bcd_split
    import cook_pkg::*;
(
    input  logic [REM_W-1:0] i_sec,
    output logic [3:0]       o_min_tens,
    output logic [3:0]       o_min_ones,
    output logic [3:0]       o_sec_tens,
    output logic [3:0]       o_sec_ones
);

    logic [REM_W-1:0] w_min;
    logic [REM_W-1:0] w_sec;

    // Divide by constants; input never exceeds 5999 so minutes stay within 0..99.
    always_comb begin
        w_min      = i_sec / REM_W'(60);
        w_sec      = i_sec % REM_W'(60);
        o_min_tens = 4'(w_min / REM_W'(10));
        o_min_ones = 4'(w_min % REM_W'(10));
        o_sec_tens = 4'(w_sec / REM_W'(10));
        o_sec_ones = 4'(w_sec % REM_W'(10));
    end

endmodule

// File: rtl/cook_timer.sv
// Cooking countdown timer: 10 s / 60 s add buttons, clear, run enable,
// one-cycle finish pulse on expiry. Define COOK_TIMER_DISPLAY_EN to add
// registered mm:ss BCD display outputs.
module cook_timer
    import cook_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             add_sec,
    input  logic             add_min,
    input  logic             clr,
    input  logic             run,
    output logic             finish,
    output logic [REM_W-1:0] remaining,
    output logic             armed
`ifdef COOK_TIMER_DISPLAY_EN
   ,output logic [3:0]       min_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    cook_state_t      r_state, w_state_nxt;
    logic [REM_W-1:0] r_rem, w_rem_nxt;
    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic             r_armed;
    logic             w_count;
    logic             w_tick;
    logic [REM_W:0]   w_sum;

    // Next-state: clear wins, then tick/adds; a bare 1->0 tick passes through DONE.
    always_comb begin
        w_count     = (r_rem != '0) && run;
        w_tick      = w_count && (r_presc == PW'(TICK_DIV - 1));
        w_sum       = {1'b0, r_rem} - (REM_W+1)'(w_tick)
                    + (add_sec ? (REM_W+1)'(SEC_STEP) : '0)
                    + (add_min ? (REM_W+1)'(MIN_STEP) : '0);
        w_rem_nxt   = sat_seconds(w_sum);
        w_presc_nxt = r_presc;
        w_state_nxt = ST_IDLE;
        if (clr) begin
            w_rem_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            if (w_count)
                w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            if (w_rem_nxt == '0) begin
                // Only a tick can bring a nonzero count to zero here.
                w_presc_nxt = '0;
                w_state_nxt = w_tick ? ST_DONE : ST_IDLE;
            end else begin
                w_state_nxt = run ? ST_RUNNING : ST_ARMED;
            end
        end
    end

    // State, counters and registered armed flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_presc <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_presc <= w_presc_nxt;
            r_armed <= (w_rem_nxt != '0);
        end
    end

    assign finish    = (r_state == ST_DONE);
    assign remaining = r_rem;
    assign armed     = r_armed;

`ifdef COOK_TIMER_DISPLAY_EN
    logic [3:0] w_mt, w_mo, w_st, w_so;
    logic [3:0] r_mt, r_mo, r_st, r_so;

    cook_bcd_split u_bcd (
        .i_sec      (r_rem),
        .o_min_tens (w_mt),
        .o_min_ones (w_mo),
        .o_sec_tens (w_st),
        .o_sec_ones (w_so)
    );

    // Display digits lag remaining by one cycle to keep the divider off the count path.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mt <= '0;
            r_mo <= '0;
            r_st <= '0;
            r_so <= '0;
        end else begin
            r_mt <= w_mt;
            r_mo <= w_mo;
            r_st <= w_st;
            r_so <= w_so;
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
`endif

endmodule
